// File: rtl/sorter_result_reader.sv
// Consumer end of the sorter: captures the packed result on done and streams
// the elements out one per cycle over a valid/ready handshake.
module sorter_result_reader #(
    parameter int WIDTH       = 16,
    parameter int NUM_OUTPUTS = 16,
    parameter bit DESCEND     = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done,
    input  logic [1:0]                   M,
    input  logic [NUM_OUTPUTS*WIDTH-1:0] y,
    output logic                         ready_in,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         dout_last,
    output logic [4:0]                   dout_idx,
    output logic [7:0]                   frame_cnt,
    output logic                         overflow,
    output logic                         bad_mode,
    input  logic                         clr_flags
);

    localparam int SEL_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] buffer [NUM_OUTPUTS];
    logic [4:0]       count, beat, pos, raw_count, mode_count;
    logic             accept_done, beat_fire, last_beat;

    always_comb begin
        raw_count = 5'd4;
        case (M)
            2'b01:   raw_count = 5'd8;
            2'b10:   raw_count = 5'd16;
            default: raw_count = 5'd4;
        endcase
        mode_count = raw_count;
        if (int'(raw_count) > NUM_OUTPUTS) begin
            mode_count = 5'(NUM_OUTPUTS);
        end
    end

    assign accept_done = done && (state == IDLE);
    assign beat_fire   = (state == STREAM) && dout_ready;
    assign last_beat   = (state == STREAM) && (beat == count - 5'd1);
    assign pos         = DESCEND ? (count - 5'd1 - beat) : beat;

    assign ready_in   = (state == IDLE);
    assign dout_valid = (state == STREAM);
    assign dout_last  = last_beat;
    assign dout_idx   = beat;
    assign dout       = (state == STREAM) ? buffer[pos[SEL_W-1:0]] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (done)                   next_state = STREAM;
            STREAM:  if (beat_fire && last_beat) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Buffer only changes on an accepted done, so a dropped pulse cannot corrupt a frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                buffer[k] <= '0;
            end
            count     <= 5'd0;
            beat      <= 5'd0;
            frame_cnt <= 8'd0;
        end else begin
            if (accept_done) begin
                for (int k = 0; k < NUM_OUTPUTS; k++) begin
                    buffer[k] <= y[k*WIDTH +: WIDTH];
                end
                count <= mode_count;
                beat  <= 5'd0;
            end else if (beat_fire && !last_beat) begin
                beat <= beat + 5'd1;
            end
            if (beat_fire && last_beat) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // A new flag event takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            bad_mode <= 1'b0;
        end else begin
            if (done && (state == STREAM)) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (accept_done && (M == 2'b11)) begin
                bad_mode <= 1'b1;
            end else if (clr_flags) begin
                bad_mode <= 1'b0;
            end
        end
    end

endmodule
